// File: rtl/grover_pkg.sv
// Shared definitions for the Grover search pipeline (phase invert, oracle,
// diffusion): default problem size, FSM state encoding and the helpers that
// give the signed saturation bounds for a given amplitude width.
package grover_pkg;

  localparam int NUM_BIT    = 3;
  localparam int AMP_WIDTH  = 8;
  localparam int NUM_SAMPLE = 1 << NUM_BIT;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ACCUM = 3'd1,
    ST_MEAN  = 3'd2,
    ST_APPLY = 3'd3,
    ST_DONE  = 3'd4
  } state_t;

  function automatic int sat_hi(input int w);
    return (1 << (w - 1)) - 1;
  endfunction

  function automatic int sat_lo(input int w);
    return -(1 << (w - 1));
  endfunction

  localparam int SAT_MAX = (1 << (AMP_WIDTH - 1)) - 1;
  localparam int SAT_MIN = -(1 << (AMP_WIDTH - 1));

endpackage

// File: rtl/grover_diffusion_sat.sv
// grover_sat: clamps an amp_width+2 bit signed value into the amp_width bit
// signed range and flags when clamping happened. Purely combinational.
//   din  : wide signed value
//   dout : saturated value
//   clip : 1 when din was outside the representable range
module grover_sat
  import grover_pkg::*;
#(
  parameter int amp_width = AMP_WIDTH
) (
  input  logic signed [amp_width+1:0] din,
  output logic signed [amp_width-1:0] dout,
  output logic                        clip
);

  localparam logic signed [amp_width+1:0] HI = (amp_width+2)'(sat_hi(amp_width));
  localparam logic signed [amp_width+1:0] LO = (amp_width+2)'(sat_lo(amp_width));

  always_comb begin
    dout = din[amp_width-1:0];
    clip = 1'b0;
    if (din > HI) begin
      dout = HI[amp_width-1:0];
      clip = 1'b1;
    end else if (din < LO) begin
      dout = LO[amp_width-1:0];
      clip = 1'b1;
    end
  end

endmodule

// File: rtl/grover_diffusion.sv
// grover_diffusion: inversion about the mean, out_k = 2*mean - A_k, with
// mean = floor(sum/num_sample). Serial: one element per cycle for the sum,
// one element per cycle through a two-stage apply pipeline.
//   clk, rst            : clock, synchronous active-high reset
//   in_valid/in_ready   : input vector handshake
//   in_amp              : packed signed amplitudes, A_k at slice k
//   out_valid/out_ready : output vector handshake
//   out_amp             : packed diffused amplitudes
//   sat                 : some element of the current result was clipped
module grover_diffusion
  import grover_pkg::*;
#(
  parameter  int num_bit    = NUM_BIT,
  parameter  int amp_width  = AMP_WIDTH,
  localparam int num_sample = 1 << num_bit
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            in_valid,
  output logic                            in_ready,
  input  logic [num_sample*amp_width-1:0] in_amp,
  output logic                            out_valid,
  input  logic                            out_ready,
  output logic [num_sample*amp_width-1:0] out_amp,
  output logic                            sat
);

  localparam int SUM_W = amp_width + num_bit;
  localparam logic [num_bit:0]   IDX_LAST  = (num_bit+1)'(num_sample - 1);
  localparam logic [num_bit:0]   IDX_END   = (num_bit+1)'(num_sample);
  localparam logic [num_bit-1:0] WIDX_LAST = (num_bit)'(num_sample - 1);

  state_t state_q, state_d;

  logic [num_sample*amp_width-1:0] vec_q;
  logic [num_sample*amp_width-1:0] out_q;
  logic [num_bit:0]                idx_q;
  logic signed [SUM_W-1:0]         sum_q;
  logic signed [amp_width:0]       two_mean_q;
  logic                            sat_q;

  logic signed [amp_width+1:0]     diff_p1;
  logic [num_bit-1:0]              widx_p1;
  logic                            vld_p1;

  logic [num_bit-1:0]              sel;
  logic signed [amp_width-1:0]     elem;
  logic signed [amp_width-1:0]     mean;
  logic signed [amp_width+1:0]     diff;
  logic signed [amp_width-1:0]     sat_dout;
  logic                            sat_clip;
  logic                            accept;
  logic                            accum_last;
  logic                            issue;
  logic                            apply_last;

  assign sel        = idx_q[num_bit-1:0];
  assign elem       = vec_q[sel*amp_width +: amp_width];
  // Arithmetic shift gives floor division, so negative sums round down.
  assign mean       = (amp_width)'(sum_q >>> num_bit);
  assign diff       = {two_mean_q[amp_width], two_mean_q} - {{2{elem[amp_width-1]}}, elem};
  assign accept     = in_valid && in_ready;
  assign accum_last = (idx_q == IDX_LAST);
  assign issue      = (state_q == ST_APPLY) && (idx_q < IDX_END);
  // DONE is reached when the last element leaves the second apply stage,
  // one cycle after it was issued.
  assign apply_last = vld_p1 && (widx_p1 == WIDX_LAST);

  grover_sat #(.amp_width(amp_width)) u_sat (
    .din  (diff_p1),
    .dout (sat_dout),
    .clip (sat_clip)
  );

  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state_q)
      ST_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_d = ST_ACCUM;
      end
      ST_ACCUM: if (accum_last) state_d = ST_MEAN;
      ST_MEAN:  state_d = ST_APPLY;
      ST_APPLY: if (apply_last) state_d = ST_DONE;
      ST_DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_d = ST_IDLE;
      end
      default:  state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      idx_q  <= '0;
      sum_q  <= '0;
      out_q  <= '0;
      sat_q  <= 1'b0;
      vld_p1 <= 1'b0;
    end else begin
      vld_p1 <= issue;
      case (state_q)
        ST_IDLE: begin
          if (accept) begin
            sum_q <= '0;
            idx_q <= '0;
            sat_q <= 1'b0;
          end
        end
        ST_ACCUM: begin
          sum_q <= sum_q + $signed({{num_bit{elem[amp_width-1]}}, elem});
          idx_q <= accum_last ? '0 : idx_q + 1'b1;
        end
        ST_MEAN: idx_q <= '0;
        ST_APPLY: begin
          if (issue) idx_q <= idx_q + 1'b1;
          // stage p1 -> result slot
          if (vld_p1) begin
            out_q[widx_p1*amp_width +: amp_width] <= sat_dout;
            sat_q <= sat_q | sat_clip;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (state_q == ST_IDLE && accept) vec_q <= in_amp;
    if (state_q == ST_MEAN) two_mean_q <= {mean, 1'b0};
    // stage p0 -> p1: unsaturated difference for the issued element
    if (issue) begin
      diff_p1 <= diff;
      widx_p1 <= sel;
    end
  end

  assign out_amp = out_q;
  assign sat     = sat_q;

endmodule
